drum_timing_xfer: RTL and testbench

- Generates drum timing for the memory lines: bit-within-word counter, word-time counter and word-boundary strobes, all locked to the 3132-bit drum_track circulation.
- Also generates the TR transfer window consumed by the memory-line block (mem_0_6) and the other line stages.
- Sits directly upstream of the memory lines. The command decoder issues a start with timing number T and next number N; this block holds TR high across whole words of the transfer.

---
 rtl/drum_timing_xfer_if.sv | 26 ++
 rtl/drum_timing_xfer.sv | 111 +++++++++++
 tb/tb_drum_timing_xfer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drum_timing_xfer_if.sv
// Command and timing bus between the command decoder, the drum timing block
// and the memory-line stages that consume bit/word timing and the TR window.
interface drum_timing_xfer_if;
    logic       CMD_START;
    logic       CMD_IMM;
    logic [6:0] CMD_T;
    logic [6:0] CMD_N;
    logic [4:0] BIT_POS;
    logic [6:0] WORD_TIME;
    logic       T0;
    logic       T29;
    logic       TR;
    logic       BUSY;
    logic       DONE;
    logic       CMD_ERR;

    modport master (
        output CMD_START, CMD_IMM, CMD_T, CMD_N,
        input  BIT_POS, WORD_TIME, T0, T29, TR, BUSY, DONE, CMD_ERR
    );

    modport slave (
        input  CMD_START, CMD_IMM, CMD_T, CMD_N,
        output BIT_POS, WORD_TIME, T0, T29, TR, BUSY, DONE, CMD_ERR
    );
endinterface

// File: rtl/drum_timing_xfer.sv
// Drum bit/word timing locked to the track circulation, plus the TR transfer
// window that spans whole words from a start word up to (not including) word N.
module drum_timing_xfer #(
    parameter int BITS_PER_WORD  = 29,
    parameter int WORDS_PER_LINE = 108
) (
    input  logic               CLOCK,
    input  logic               rst,
    drum_timing_xfer_if.slave  bus
);
    localparam logic [4:0] LAST_BIT  = 5'(BITS_PER_WORD - 1);
    localparam logic [6:0] LAST_WORD = 7'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

    state_t     state, state_nxt;
    logic [4:0] bit_pos, bit_nxt;
    logic [6:0] word_time, word_nxt;
    logic [6:0] t_q, n_q;
    logic       imm_q;
    logic       tr_q, busy_q, done_q, err_q;
    logic       tr_nxt, busy_nxt, done_nxt, err_nxt;
    logic       at_boundary, cmd_bad, cmd_ok;

    always_comb begin
        bit_nxt  = (bit_pos == LAST_BIT) ? 5'd0 : bit_pos + 5'd1;
        word_nxt = word_time;
        if (bit_pos == LAST_BIT)
            word_nxt = (word_time == LAST_WORD) ? 7'd0 : word_time + 7'd1;
    end

    // Every decision is made against the position the drum is about to reach,
    // so TR changes exactly in the bit-0 cycle of a word.
    assign at_boundary = (bit_nxt == 5'd0);
    assign cmd_bad     = (bus.CMD_T > LAST_WORD) || (bus.CMD_N > LAST_WORD);
    assign cmd_ok      = (state == IDLE) && bus.CMD_START && !cmd_bad;

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A start landing right before its word's bit 0 goes straight to XFER.
                if (cmd_ok) begin
                    if (at_boundary && (bus.CMD_IMM || word_nxt == bus.CMD_T))
                        state_nxt = XFER;
                    else
                        state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (at_boundary && (imm_q || word_nxt == t_q))
                    state_nxt = XFER;
            end
            XFER: begin
                if (at_boundary && word_nxt == n_q)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tr_nxt   = (state_nxt == XFER);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == XFER) && (state_nxt == IDLE);
        err_nxt  = (state == IDLE) && bus.CMD_START && cmd_bad;
    end

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            bit_pos   <= 5'd0;
            word_time <= 7'd0;
            t_q       <= 7'd0;
            n_q       <= 7'd0;
            imm_q     <= 1'b0;
            tr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bit_pos   <= bit_nxt;
            word_time <= word_nxt;
            tr_q      <= tr_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            if (cmd_ok) begin
                t_q   <= bus.CMD_T;
                n_q   <= bus.CMD_N;
                imm_q <= bus.CMD_IMM;
            end
        end
    end

    assign bus.BIT_POS   = bit_pos;
    assign bus.WORD_TIME = word_time;
    assign bus.T0        = (bit_pos == 5'd0);
    assign bus.T29       = (bit_pos == LAST_BIT);
    assign bus.TR        = tr_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.CMD_ERR   = err_q;
endmodule

// File: tb/tb_drum_timing_xfer.sv
// Directed bench for drum_timing_xfer: counter wrap, transfer windows,
// boundary starts, busy/error handling and reset abort.
module tb_drum_timing_xfer;
    logic CLOCK = 1'b0;
    logic rst   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    drum_timing_xfer_if bus ();

    drum_timing_xfer dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic issue(input logic imm, input logic [6:0] t, input logic [6:0] n);
        bus.CMD_START = 1'b1;
        bus.CMD_IMM   = imm;
        bus.CMD_T     = t;
        bus.CMD_N     = n;
        tick();
        bus.CMD_START = 1'b0;
    endtask

    task automatic wait_until(input int w, input int b);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            if (int'(bus.WORD_TIME) == w && int'(bus.BIT_POS) == b) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!hit) $display("FAIL wait_until timeout waiting for %0d/%0d", w, b);
        else n_pass++;
    endtask

    // Observes the bus from the current cycle until DONE (inclusive).
    task automatic measure(output int rise_idx, output int rise_w, output int rise_b,
                           output int tr_cnt, output int fall_w, output int fall_b,
                           output int done_w, output int done_b, output bit done_seen);
        bit rose, fell;
        rose = 0; fell = 0;
        rise_idx = -1; rise_w = -1; rise_b = -1; tr_cnt = 0;
        fall_w = -1; fall_b = -1; done_w = -1; done_b = -1; done_seen = 0;
        for (int i = 0; i < 7000; i++) begin
            if (bus.TR) begin
                if (!rose) begin
                    rose = 1; rise_idx = i;
                    rise_w = int'(bus.WORD_TIME); rise_b = int'(bus.BIT_POS);
                end
                tr_cnt++;
            end else if (rose && !fell) begin
                fell = 1; fall_w = int'(bus.WORD_TIME); fall_b = int'(bus.BIT_POS);
            end
            if (bus.DONE) begin
                done_seen = 1; done_w = int'(bus.WORD_TIME); done_b = int'(bus.BIT_POS);
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.BIT_POS !== 5'd0 || bus.WORD_TIME !== 7'd0)
            $display("FAIL reset_counters got %0d/%0d want 0/0", bus.BIT_POS, bus.WORD_TIME);
        else n_pass++;
        n_checks++;
        if (bus.T0 !== 1'b1 || bus.T29 !== 1'b0)
            $display("FAIL reset_strobes got T0=%b T29=%b want 1/0", bus.T0, bus.T29);
        else n_pass++;
        n_checks++;
        if ({bus.TR, bus.BUSY, bus.DONE, bus.CMD_ERR} !== 4'b0000)
            $display("FAIL reset_flags got TR,BUSY,DONE,ERR=%b want 0000",
                     {bus.TR, bus.BUSY, bus.DONE, bus.CMD_ERR});
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_counter_wrap();
        int t0_cnt, t29_cnt, bad, tr_seen;
        t0_cnt = 0; t29_cnt = 0; bad = 0; tr_seen = 0;
        for (int i = 0; i < 3132; i++) begin
            if (int'(bus.BIT_POS) != i % 29 || int'(bus.WORD_TIME) != i / 29) bad++;
            if (bus.T0) t0_cnt++;
            if (bus.T29) t29_cnt++;
            if (bus.TR) tr_seen++;
            if (i == 3131) begin
                n_checks++;
                if (bus.WORD_TIME !== 7'd107 || bus.BIT_POS !== 5'd28)
                    $display("FAIL wrap_last got %0d/%0d want 107/28", bus.WORD_TIME, bus.BIT_POS);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (bad != 0) $display("FAIL wrap_sequence got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (bus.WORD_TIME !== 7'd0 || bus.BIT_POS !== 5'd0)
            $display("FAIL wrap_return got %0d/%0d want 0/0", bus.WORD_TIME, bus.BIT_POS);
        else n_pass++;
        n_checks++;
        if (t0_cnt != 108 || t29_cnt != 108)
            $display("FAIL wrap_strobes got T0=%0d T29=%0d want 108/108", t0_cnt, t29_cnt);
        else n_pass++;
        n_checks++;
        if (tr_seen != 0) $display("FAIL wrap_idle_tr got %0d want 0", tr_seen);
        else n_pass++;
    endtask

    task automatic test_deferred();
        int ri, rw, rb, cnt, fw, fb, dw, db;
        bit ds;
        wait_until(2, 5);
        issue(1'b0, 7'd10, 7'd13);
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.TR !== 1'b0)
            $display("FAIL deferred_wait got BUSY=%b TR=%b want 1/0", bus.BUSY, bus.TR);
        else n_pass++;
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        n_checks++;
        if (!ds || rw != 10 || rb != 0 || cnt != 87 || fw != 13 || fb != 0 || dw != 13 || db != 0)
            $display("FAIL deferred got done=%0b rise=%0d/%0d cnt=%0d fall=%0d/%0d done_at=%0d/%0d want 1 10/0 87 13/0 13/0",
                     ds, rw, rb, cnt, fw, fb, dw, db);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0)
            $display("FAIL deferred_after got BUSY=%b DONE=%b want 0/0", bus.BUSY, bus.DONE);
        else n_pass++;
    endtask

    task automatic test_immediate_wrap();
        int ri, rw, rb, cnt, fw, fb, dw, db;
        bit ds;
        wait_until(106, 3);
        issue(1'b1, 7'd50, 7'd1);
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        n_checks++;
        if (!ds || rw != 107 || rb != 0 || cnt != 58 || dw != 1 || db != 0)
            $display("FAIL immediate got done=%0b rise=%0d/%0d cnt=%0d done_at=%0d/%0d want 1 107/0 58 1/0",
                     ds, rw, rb, cnt, dw, db);
        else n_pass++;
    endtask

    task automatic test_full_rev();
        int ri, rw, rb, cnt, fw, fb, dw, db;
        bit ds;
        tick();
        issue(1'b0, 7'd20, 7'd20);
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        n_checks++;
        if (!ds || rw != 20 || rb != 0 || cnt != 3132 || dw != 20 || db != 0)
            $display("FAIL full_rev got done=%0b rise=%0d/%0d cnt=%0d done_at=%0d/%0d want 1 20/0 3132 20/0",
                     ds, rw, rb, cnt, dw, db);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int ri, rw, rb, cnt, fw, fb, dw, db;
        bit ds;
        wait_until(9, 28);
        issue(1'b0, 7'd10, 7'd11);
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        n_checks++;
        if (!ds || ri != 0 || rw != 10 || rb != 0 || cnt != 29 || dw != 11 || db != 0)
            $display("FAIL boundary_next got done=%0b idx=%0d rise=%0d/%0d cnt=%0d done_at=%0d/%0d want 1 0 10/0 29 11/0",
                     ds, ri, rw, rb, cnt, dw, db);
        else n_pass++;
        wait_until(10, 0);
        issue(1'b0, 7'd10, 7'd11);
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        n_checks++;
        if (!ds || ri != 3131 || rw != 10 || rb != 0 || cnt != 29)
            $display("FAIL boundary_rev got done=%0b idx=%0d rise=%0d/%0d cnt=%0d want 1 3131 10/0 29",
                     ds, ri, rw, rb, cnt);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int ri, rw, rb, cnt, fw, fb, dw, db;
        bit ds;
        issue(1'b0, 7'd30, 7'd32);
        wait_until(31, 5);
        issue(1'b1, 7'd40, 7'd41);
        n_checks++;
        if (bus.CMD_ERR !== 1'b0 || bus.TR !== 1'b1)
            $display("FAIL busy_ignore_now got ERR=%b TR=%b want 0/1", bus.CMD_ERR, bus.TR);
        else n_pass++;
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        n_checks++;
        if (!ds || ri != 0 || cnt != 23 || dw != 32 || db != 0)
            $display("FAIL busy_ignore got done=%0b idx=%0d cnt=%0d done_at=%0d/%0d want 1 0 23 32/0",
                     ds, ri, cnt, dw, db);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ri, rw, rb, cnt, fw, fb, dw, db;
        bit ds;
        issue(1'b0, 7'd60, 7'd61);
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        issue(1'b1, 7'd0, 7'd63);
        n_checks++;
        if (!ds || bus.BUSY !== 1'b1)
            $display("FAIL b2b_accept got done=%0b BUSY=%b want 1/1", ds, bus.BUSY);
        else n_pass++;
        measure(ri, rw, rb, cnt, fw, fb, dw, db, ds);
        n_checks++;
        if (!ds || rw != 62 || rb != 0 || cnt != 29 || dw != 63 || db != 0)
            $display("FAIL b2b got done=%0b rise=%0d/%0d cnt=%0d done_at=%0d/%0d want 1 62/0 29 63/0",
                     ds, rw, rb, cnt, dw, db);
        else n_pass++;
    endtask

    task automatic test_error();
        int tr_seen;
        tick();
        issue(1'b0, 7'd110, 7'd5);
        n_checks++;
        if ({bus.CMD_ERR, bus.BUSY, bus.TR} !== 3'b100)
            $display("FAIL err_t got ERR,BUSY,TR=%b want 100", {bus.CMD_ERR, bus.BUSY, bus.TR});
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.CMD_ERR, bus.BUSY} !== 2'b00)
            $display("FAIL err_pulse got ERR,BUSY=%b want 00", {bus.CMD_ERR, bus.BUSY});
        else n_pass++;
        issue(1'b1, 7'd120, 7'd3);
        n_checks++;
        if (bus.CMD_ERR !== 1'b1)
            $display("FAIL err_imm_t got ERR=%b want 1", bus.CMD_ERR);
        else n_pass++;
        tr_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.TR || bus.BUSY) tr_seen++;
            tick();
        end
        n_checks++;
        if (tr_seen != 0) $display("FAIL err_no_xfer got %0d busy cycles want 0", tr_seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int done_cnt, tr_cnt;
        issue(1'b0, 7'd50, 7'd55);
        wait_until(52, 10);
        n_checks++;
        if (bus.TR !== 1'b1) $display("FAIL rst_mid_pre got TR=%b want 1", bus.TR);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.TR, bus.BUSY, bus.DONE} !== 3'b000 || bus.BIT_POS !== 5'd0 || bus.WORD_TIME !== 7'd0)
            $display("FAIL rst_mid got TR,BUSY,DONE=%b pos=%0d/%0d want 000 0/0",
                     {bus.TR, bus.BUSY, bus.DONE}, bus.WORD_TIME, bus.BIT_POS);
        else n_pass++;
        rst = 1'b1;
        done_cnt = 0; tr_cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            if (bus.DONE) done_cnt++;
            if (bus.TR) tr_cnt++;
            tick();
        end
        n_checks++;
        if (done_cnt != 0 || tr_cnt != 0)
            $display("FAIL rst_mid_after got DONE=%0d TR=%0d want 0/0", done_cnt, tr_cnt);
        else n_pass++;
    endtask

    initial begin
        bus.CMD_START = 1'b0;
        bus.CMD_IMM   = 1'b0;
        bus.CMD_T     = 7'd0;
        bus.CMD_N     = 7'd0;
        test_reset();
        test_counter_wrap();
        test_deferred();
        test_immediate_wrap();
        test_full_rev();
        test_boundary();
        test_busy_ignore();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
